// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_pkg
// Description : Shared constants for the mult/div issue controller.
// Revision    : 1.0 - initial release
// ============================================================================
package multdiv_pkg;

    localparam logic [1:0] C_S_IDLE  = 2'd0;
    localparam logic [1:0] C_S_START = 2'd1;
    localparam logic [1:0] C_S_WAIT  = 2'd2;
    localparam logic [1:0] C_S_DONE  = 2'd3;

    localparam logic       C_OP_MULT = 1'b0;
    localparam logic       C_OP_DIV  = 1'b1;

    localparam int         C_RSTATUS_REG   = 30;
    localparam int         C_MULT_EXC_CODE = 4;
    localparam int         C_DIV_EXC_CODE  = 5;
    localparam int         C_CNT_W         = 7;

endpackage : multdiv_pkg
`default_nettype wire

// File: rtl/multdiv_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_issue_ctrl_if
// Description : X-stage request, multdiv handshake and writeback bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface multdiv_issue_ctrl_if;

    logic        start_mult;
    logic        start_div;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [4:0]  rd_in;
    logic        flush;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic [31:0] md_result;
    logic        md_except;
    logic        md_ready;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy;

    // Environment side: pipeline plus multdiv
    modport master (
        output start_mult, start_div, opA, opB, rd_in, flush,
        output md_result, md_except, md_ready,
        input  md_operandA, md_operandB, md_ctrl_mult, md_ctrl_div,
        input  stall, wb_valid, wb_rd, wb_data, busy
    );

    // Controller side
    modport slave (
        input  start_mult, start_div, opA, opB, rd_in, flush,
        input  md_result, md_except, md_ready,
        output md_operandA, md_operandB, md_ctrl_mult, md_ctrl_div,
        output stall, wb_valid, wb_rd, wb_data, busy
    );

endinterface : multdiv_issue_ctrl_if
`default_nettype wire

// File: rtl/multdiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_issue_ctrl
// Description : Issues one mult/div to multdiv, stalls until done, writes back.
// Revision    : 1.0 - initial release
// ============================================================================
module multdiv_issue_ctrl
    import multdiv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MULT_EXC_CODE  = C_MULT_EXC_CODE,
    parameter int DIV_EXC_CODE   = C_DIV_EXC_CODE,
    parameter int RSTATUS_REG    = C_RSTATUS_REG
) (
    input  wire logic            clock,
    input  wire logic            reset,
    multdiv_issue_ctrl_if.slave  bus
);

    localparam logic [C_CNT_W-1:0] C_CNT_LAST  = C_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]         C_RSTATUS   = 5'(RSTATUS_REG);
    localparam logic [31:0]        C_MULT_CODE = 32'(MULT_EXC_CODE);
    localparam logic [31:0]        C_DIV_CODE  = 32'(DIV_EXC_CODE);

    logic [1:0]         r_state;
    logic [31:0]        r_opa;
    logic [31:0]        r_opb;
    logic [4:0]         r_rd;
    logic               r_op;
    logic [C_CNT_W-1:0] r_cnt;
    logic [31:0]        r_result;
    logic               r_except;

    logic               w_req;
    logic               w_idle;
    logic               w_start;
    logic               w_wait;
    logic               w_done;

    assign w_req   = bus.start_mult | bus.start_div;
    assign w_idle  = (r_state == C_S_IDLE);
    assign w_start = (r_state == C_S_START);
    assign w_wait  = (r_state == C_S_WAIT);
    assign w_done  = (r_state == C_S_DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= C_S_IDLE;
            r_opa    <= '0;
            r_opb    <= '0;
            r_rd     <= '0;
            r_op     <= C_OP_MULT;
            r_cnt    <= '0;
            r_result <= '0;
            r_except <= 1'b0;
        end else if (bus.flush) begin
            // Squash: multdiv keeps running, its later ready is simply not looked at
            r_state <= C_S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                C_S_IDLE: begin
                    if (w_req) begin
                        r_opa   <= bus.opA;
                        r_opb   <= bus.opB;
                        r_rd    <= bus.rd_in;
                        r_op    <= bus.start_mult ? C_OP_MULT : C_OP_DIV;
                        r_state <= C_S_START;
                    end
                end
                C_S_START: begin
                    // md_ready here may still belong to the previous op
                    r_cnt   <= '0;
                    r_state <= C_S_WAIT;
                end
                C_S_WAIT: begin
                    if (bus.md_ready) begin
                        r_result <= bus.md_result;
                        r_except <= bus.md_except;
                        r_state  <= C_S_DONE;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_except <= 1'b1;
                        r_state  <= C_S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                C_S_DONE: begin
                    r_state <= C_S_IDLE;
                end
                default: begin
                    r_state <= C_S_IDLE;
                end
            endcase
        end
    end

    assign bus.md_operandA  = r_opa;
    assign bus.md_operandB  = r_opb;
    assign bus.md_ctrl_mult = w_start & (r_op == C_OP_MULT);
    assign bus.md_ctrl_div  = w_start & (r_op == C_OP_DIV);
    assign bus.stall        = (w_idle & w_req) | w_start | w_wait;
    assign bus.busy         = ~w_idle;

    // r0 is never written, but rd/data stay visible on the bus
    assign bus.wb_valid = w_done & ~bus.flush & (r_except | (r_rd != 5'd0));
    assign bus.wb_rd    = ~w_done ? 5'd0 : (r_except ? C_RSTATUS : r_rd);
    assign bus.wb_data  = ~w_done ? 32'd0 :
                          (r_except ? ((r_op == C_OP_MULT) ? C_MULT_CODE : C_DIV_CODE)
                                    : r_result);

endmodule : multdiv_issue_ctrl
`default_nettype wire

// File: tb/tb_multdiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multdiv_issue_ctrl
// Description : Self-checking bench; acts as pipeline and multdiv model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_issue_ctrl;

    localparam int C_TIMEOUT = 64;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    multdiv_issue_ctrl_if bus ();

    multdiv_issue_ctrl #(
        .TIMEOUT_CYCLES (C_TIMEOUT),
        .MULT_EXC_CODE  (4),
        .DIV_EXC_CODE   (5),
        .RSTATUS_REG    (30)
    ) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},  32'(bus.busy), 32'd0);
        chk({tag, "_wbv"},   32'(bus.wb_valid), 32'd0);
        chk({tag, "_pulse"}, {30'd0, bus.md_ctrl_mult, bus.md_ctrl_div}, 32'd0);
    endtask

    // One complete operation. k = WAIT cycle on which multdiv answers (0 = never);
    // f = WAIT cycle on which flush is raised (0 = none).
    task automatic run_op(input bit sm, input bit sd, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int k, input bit force_exc, input int f);
        bit          is_mult;
        bit          exc;
        bit          timed_out;
        bit          exp_exc;
        logic [31:0] res;
        int          n_wait;
        is_mult = sm;
        if (is_mult) begin
            res = $signed(a) * $signed(b);
            exc = force_exc;
        end else if (b == 32'd0) begin
            res = $urandom;
            exc = 1'b1;
        end else begin
            res = $signed(a) / $signed(b);
            exc = force_exc;
        end
        timed_out = (k == 0) || (k > C_TIMEOUT);
        n_wait    = timed_out ? C_TIMEOUT : k;

        @(negedge clock);
        bus.start_mult = sm; bus.start_div = sd;
        bus.opA = a; bus.opB = b; bus.rd_in = rd; bus.md_ready = 1'b0;
        #1;
        chk("req_stall", 32'(bus.stall), 32'd1);
        chk_idle_outputs("req");

        // Stale ready/result during START must be ignored
        @(negedge clock);
        bus.start_mult = 1'b0; bus.start_div = 1'b0;
        bus.opA = $urandom; bus.opB = $urandom; bus.rd_in = 5'($urandom);
        bus.md_ready = 1'($urandom_range(0, 1)); bus.md_result = $urandom;
        bus.md_except = 1'($urandom_range(0, 1));
        #1;
        chk("start_mult", 32'(bus.md_ctrl_mult), 32'(is_mult));
        chk("start_div",  32'(bus.md_ctrl_div),  32'(!is_mult));
        chk("start_opa",  bus.md_operandA, a);
        chk("start_opb",  bus.md_operandB, b);
        chk("start_stall", 32'(bus.stall), 32'd1);
        chk("start_wbv",  32'(bus.wb_valid), 32'd0);

        for (int j = 1; j <= n_wait; j++) begin
            @(negedge clock);
            bus.md_ready  = (j == k);
            bus.md_result = (j == k) ? res : $urandom;
            bus.md_except = (j == k) ? exc : 1'($urandom_range(0, 1));
            bus.flush     = (j == f);
            #1;
            chk("wait_pulse", {30'd0, bus.md_ctrl_mult, bus.md_ctrl_div}, 32'd0);
            chk("wait_stall", 32'(bus.stall), 32'd1);
            chk("wait_busy",  32'(bus.busy), 32'd1);
            chk("wait_wbv",   32'(bus.wb_valid), 32'd0);
            chk("wait_opa",   bus.md_operandA, a);
            if (j == f) begin
                @(negedge clock);
                bus.flush = 1'b0; bus.md_ready = 1'b1; bus.md_result = $urandom;
                #1;
                chk_idle_outputs("flush1");
                chk("flush1_stall", 32'(bus.stall), 32'd0);
                @(negedge clock);
                bus.md_ready = 1'b0;
                #1;
                chk_idle_outputs("flush2");
                return;
            end
        end

        @(negedge clock);
        bus.md_ready = 1'b0; bus.md_except = 1'($urandom_range(0, 1));
        #1;
        exp_exc = timed_out ? 1'b1 : exc;
        chk("done_wbv",   32'(bus.wb_valid), 32'(exp_exc || (rd != 5'd0)));
        chk("done_wbrd",  32'(bus.wb_rd), exp_exc ? 32'd30 : 32'(rd));
        chk("done_wbdat", bus.wb_data, exp_exc ? (is_mult ? 32'd4 : 32'd5) : res);
        chk("done_stall", 32'(bus.stall), 32'd0);
        chk("done_busy",  32'(bus.busy), 32'd1);
    endtask

    initial begin
        int          sel, r, n, f;
        logic [31:0] a, b;
        bus.start_mult = 1'b0; bus.start_div = 1'b0; bus.opA = '0; bus.opB = '0;
        bus.rd_in = '0; bus.flush = 1'b0; bus.md_result = '0; bus.md_except = 1'b0;
        bus.md_ready = 1'b0;

        repeat (3) @(negedge clock);
        chk_idle_outputs("rst");
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_opa", bus.md_operandA, 32'd0);
        chk("rst_wbrd", 32'(bus.wb_rd), 32'd0);
        chk("rst_wbdat", bus.wb_data, 32'd0);
        reset = 1'b0;

        run_op(1, 0, 32'd7, -32'sd3, 5'd5, 32, 0, 0);
        run_op(0, 1, 32'd100, 32'd0, 5'd9, 3, 0, 0);
        run_op(1, 0, 32'd6, 32'd7, 5'd0, 5, 0, 0);
        run_op(0, 1, 32'd50, 32'd7, 5'd12, 0, 0, 0);
        run_op(1, 0, 32'd3, 32'd3, 5'd8, 0, 0, 0);
        run_op(0, 1, 32'd9, 32'd3, 5'd6, 10, 0, 3);
        run_op(0, 1, 32'd10, 32'd2, 5'd4, 4, 0, 0);
        run_op(1, 1, 32'd11, 32'd12, 5'd13, 2, 0, 0);
        run_op(0, 1, 32'd77, 32'd11, 5'd14, 64, 0, 0);
        run_op(1, 0, 32'd5, 32'd5, 5'd15, 1, 1, 0);

        // Flush together with a request: the request is dropped
        @(negedge clock);
        bus.start_mult = 1'b1; bus.flush = 1'b1;
        @(negedge clock);
        bus.start_mult = 1'b0; bus.flush = 1'b0;
        #1;
        chk_idle_outputs("flushreq");

        // Reset in the middle of an op clears everything
        @(negedge clock);
        bus.start_div = 1'b1; bus.opA = 32'hDEAD; bus.opB = 32'hBEEF; bus.rd_in = 5'd3;
        @(negedge clock);
        bus.start_div = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk_idle_outputs("midrst");
        chk("midrst_opa", bus.md_operandA, 32'd0);
        chk("midrst_opb", bus.md_operandB, 32'd0);

        for (int i = 0; i < 25; i++) begin
            sel = $urandom_range(0, 2);
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
            if ($urandom_range(0, 1) == 1) b = -b;
            if (b == 32'hFFFF_FFFF) b = 32'd2;
            r = $urandom_range(0, 9);
            n = (r == 0) ? 0 : ((r == 1) ? 64 : $urandom_range(1, 40));
            f = 0;
            if ($urandom_range(0, 4) == 0) begin
                if (n == 0) f = $urandom_range(1, C_TIMEOUT - 1);
                else if (n > 1) f = $urandom_range(1, n - 1);
            end
            run_op(sel != 1, sel != 0, a, b, 5'($urandom), n,
                   ($urandom_range(0, 3) == 0), f);
        end

        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_multdiv_issue_ctrl
`default_nettype wire
